// File: rtl/wb_rr_arbiter2_if.sv
// Wishbone classic bus bundle used for both arbiter master ports and the shared slave port.
interface wb_rr_arbiter2_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] sel;
    logic [DW-1:0] rdata;
    logic          ack;

    modport master (output cyc, stb, we, addr, wdata, sel, input rdata, ack);
    modport slave  (input cyc, stb, we, addr, wdata, sel, output rdata, ack);
endinterface

// File: rtl/wb_rr_arbiter2.sv
// Two-master Wishbone classic round-robin arbiter with a no-ack watchdog.
// One transfer at a time; grant is released after every ack, abort or timeout.
module wb_rr_arbiter2 #(
    parameter int WB_AD_WIDTH  = 32,
    parameter int WB_DAT_WIDTH = 32,
    parameter int TIMEOUT      = 255
) (
    input  logic             clk,
    input  logic             rst,
    wb_rr_arbiter2_if.slave  m0,
    wb_rr_arbiter2_if.slave  m1,
    wb_rr_arbiter2_if.master s,
    output logic             timeout_o
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [9:0]              TO     = 10'(TIMEOUT);
    localparam logic [WB_DAT_WIDTH-1:0] MARKER = WB_DAT_WIDTH'(32'hDEAD_BEEF);

    state_t state, state_n;
    logic   gnt, gnt_n, last, last_n;
    logic [9:0] cnt, cnt_n;

    logic req0, req1;
    logic g_cyc, g_stb, g_we;
    logic [WB_AD_WIDTH-1:0]    g_addr;
    logic [WB_DAT_WIDTH-1:0]   g_wdata;
    logic [WB_DAT_WIDTH/8-1:0] g_sel;
    logic                      ack_g;
    logic [WB_DAT_WIDTH-1:0]   rd_g;

    assign req0 = m0.cyc & m0.stb;
    assign req1 = m1.cyc & m1.stb;

    assign g_cyc   = gnt ? m1.cyc   : m0.cyc;
    assign g_stb   = gnt ? m1.stb   : m0.stb;
    assign g_we    = gnt ? m1.we    : m0.we;
    assign g_addr  = gnt ? m1.addr  : m0.addr;
    assign g_wdata = gnt ? m1.wdata : m0.wdata;
    assign g_sel   = gnt ? m1.sel   : m0.sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= 1'b0;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            last  <= last_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        last_n    = last;
        cnt_n     = cnt;
        s.cyc     = 1'b0;
        s.stb     = 1'b0;
        s.we      = 1'b0;
        s.addr    = '0;
        s.wdata   = '0;
        s.sel     = '0;
        ack_g     = 1'b0;
        rd_g      = '0;
        timeout_o = 1'b0;
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    // on a tie the master that was not served last wins
                    gnt_n   = (req0 & req1) ? ~last : req1;
                    last_n  = gnt_n;
                    cnt_n   = '0;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                s.cyc   = g_cyc;
                s.stb   = g_stb;
                s.we    = g_we;
                s.addr  = g_addr;
                s.wdata = g_wdata;
                s.sel   = g_sel;
                rd_g    = s.rdata;
                if (!g_cyc) begin
                    state_n = IDLE;
                end else if (s.ack) begin
                    ack_g   = 1'b1;
                    state_n = IDLE;
                end else if (cnt == TO) begin
                    ack_g     = 1'b1;
                    rd_g      = MARKER;
                    timeout_o = 1'b1;
                    state_n   = IDLE;
                end else if (cnt != '1) begin
                    cnt_n = cnt + 10'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // ungranted master always sees a quiet bus
    assign m0.ack   = ack_g & ~gnt;
    assign m0.rdata = gnt ? '0 : rd_g;
    assign m1.ack   = ack_g & gnt;
    assign m1.rdata = gnt ? rd_g : '0;
endmodule
